// File: rtl/ahb_default_slave_ext.sv
// ----------------------------------------------------------------------------
// ahb_default_slave_ext
//
// AHB default slave. The address decoder selects it (HSEL) for every
// transfer that lands in unmapped address space. It answers each accepted
// NONSEQ/SEQ transfer with optional wait states followed by either the
// two-cycle ERROR response (RESP_MODE=1) or a single OKAY cycle
// (RESP_MODE=0, read-as-zero / write-ignored, read data = RDATA_VALUE).
// In RESP_MODE=1 it also logs the first faulting transfer and counts errors.
//
// Ports
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   HSEL            default-slave select from the decoder
//   HADDR, HWRITE   address / direction of the transfer (logged)
//   HTRANS          IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//   HSIZE, HBURST, HWDATA, HMASTLOCK   not used by this slave
//   HMASTER         id of the master owning the address phase (logged)
//   HREADYIN        bus-wide HREADY from the response mux
//   HREADY, HRESP   slave ready and response (OKAY=00, ERROR=01)
//   HRDATA          read data, non-zero only in an RESP_MODE=0 read response
//   HSPLIT          split-resume vector, tied to zero
//   err_clear       one-cycle pulse clearing err_valid and err_count
//   err_valid/addr/master/write   first captured fault
//   err_count       saturating fault counter
//   state_dbg       current FSM state (IDLE=0 WAIT=1 ERR1=2 ERR2=3 DONE=4)
//
// Handshake: a transfer is accepted on the rising HCLK edge that ends its
// address phase, i.e. when HSEL, HREADYIN and HTRANS[1] are all high at that
// edge. The data phase lasts until HREADY is seen high; while HREADY is low
// the bus holds the next address phase.
// ----------------------------------------------------------------------------
module ahb_default_slave_ext #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_MASTERS = 4,
    parameter int                WAIT_STATES = 0,
    parameter int                RESP_MODE   = 1,
    parameter logic [DATA_W-1:0] RDATA_VALUE = '0,
    parameter int                CNT_W       = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HSEL,
    input  logic [ADDR_W-1:0]      HADDR,
    input  logic                   HWRITE,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HSIZE,
    input  logic [2:0]             HBURST,
    input  logic [DATA_W-1:0]      HWDATA,
    input  logic [3:0]             HMASTER,
    input  logic                   HMASTLOCK,
    input  logic                   HREADYIN,
    output logic                   HREADY,
    output logic [1:0]             HRESP,
    output logic [DATA_W-1:0]      HRDATA,
    output logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic                   err_clear,
    output logic                   err_valid,
    output logic [ADDR_W-1:0]      err_addr,
    output logic [3:0]             err_master,
    output logic                   err_write,
    output logic [CNT_W-1:0]       err_count,
    output logic [2:0]             state_dbg
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ERR1 = 3'd2,
        ST_ERR2 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // State entered once the wait states (if any) have elapsed.
    localparam state_t RESP_STATE  = (RESP_MODE != 0) ? ST_ERR1 : ST_DONE;
    // State entered on the edge that accepts a transfer.
    localparam state_t FIRST_STATE = (WAIT_STATES > 0) ? ST_WAIT : RESP_STATE;
    // The WAIT state is entered with this count and left when it reaches 0,
    // giving exactly WAIT_STATES low-HREADY OKAY cycles.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic write_q, write_d;
    logic accept;
    logic take;
    logic ready_d;
    logic [1:0] resp_d;
    logic [DATA_W-1:0] rdata_d;

    assign accept = HSEL & HREADYIN & HTRANS[1];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        write_d    = write_q;
        take       = 1'b0;
        case (state_q)
            // HREADY is high in these states, so a new address phase can end here.
            ST_IDLE, ST_ERR2, ST_DONE: begin
                if (accept) begin
                    take = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = RESP_STATE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            state_d    = FIRST_STATE;
            wait_cnt_d = WAIT_LOAD;
            write_d    = HWRITE;
        end
    end

    // Bus outputs are decoded from the next state so that they come straight
    // out of flops in the cycle the state is entered.
    always_comb begin
        ready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        resp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
        rdata_d = ((state_d == ST_DONE) && !write_d) ? RDATA_VALUE : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            write_q    <= 1'b0;
            HREADY     <= 1'b1;
            HRESP      <= RESP_OKAY;
            HRDATA     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            write_q    <= write_d;
            HREADY     <= ready_d;
            HRESP      <= resp_d;
            HRDATA     <= rdata_d;
        end
    end

    // Error log. A clear coinciding with a new fault makes that fault the
    // first one: it is captured and the count restarts at 1.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_valid  <= 1'b0;
            err_addr   <= '0;
            err_master <= 4'd0;
            err_write  <= 1'b0;
            err_count  <= '0;
        end else if (RESP_MODE != 0) begin
            if (take) begin
                if (err_clear || !err_valid) begin
                    err_valid  <= 1'b1;
                    err_addr   <= HADDR;
                    err_master <= HMASTER;
                    err_write  <= HWRITE;
                end
                if (err_clear) begin
                    err_count <= CNT_W'(1);
                end else if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end else if (err_clear) begin
                err_valid <= 1'b0;
                err_count <= '0;
            end
        end
    end

    assign HSPLIT    = '0;
    assign state_dbg = state_q;

    logic unused_inputs;
    assign unused_inputs = ^{HSIZE, HBURST, HWDATA, HMASTLOCK};

endmodule

// File: tb/tb_ahb_default_slave_ext.sv
// ----------------------------------------------------------------------------
// tb_ahb_default_slave_ext
//
// Three instances of the default slave with different configurations:
//   a: WAIT_STATES=0, RESP_MODE=1, CNT_W=2
//   b: WAIT_STATES=3, RESP_MODE=1, CNT_W=8
//   c: WAIT_STATES=1, RESP_MODE=0, RDATA_VALUE=0xDEADBEEF
// Each instance's HREADYIN is its own HREADY (single-slave bus) unless the
// bench forces it low with 'hold'. Expected per-cycle responses are queued
// when an address phase is driven and popped each following cycle.
// ----------------------------------------------------------------------------
module tb_ahb_default_slave_ext;

    // ---------------- clock / reset ----------------
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    // ---------------- shared bus inputs ----------------
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b010;
    logic [2:0]  hburst = 3'b000;
    logic [31:0] hwdata = '0;
    logic [3:0]  hmaster = '0;
    logic        hmastlock = 1'b0;
    logic        hold = 1'b0;

    // ---------------- per-instance signals ----------------
    logic hsel_a = 1'b0, hsel_b = 1'b0, hsel_c = 1'b0;
    logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
    logic hready_a, hready_b, hready_c;
    logic hreadyin_a, hreadyin_b, hreadyin_c;
    logic [1:0] hresp_a, hresp_b, hresp_c;
    logic [31:0] hrdata_a, hrdata_b, hrdata_c;
    logic [3:0] hsplit_a, hsplit_b, hsplit_c;
    logic ev_a, ev_b, ev_c;
    logic [31:0] ea_a, ea_b, ea_c;
    logic [3:0] em_a, em_b, em_c;
    logic ew_a, ew_b, ew_c;
    logic [1:0] ec_a;
    logic [7:0] ec_b, ec_c;
    logic [2:0] st_a, st_b, st_c;

    assign hreadyin_a = hready_a & ~hold;
    assign hreadyin_b = hready_b & ~hold;
    assign hreadyin_c = hready_c & ~hold;

    ahb_default_slave_ext #(.WAIT_STATES(0), .RESP_MODE(1), .CNT_W(2)) u_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_a), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HMASTER(hmaster),
        .HMASTLOCK(hmastlock), .HREADYIN(hreadyin_a), .HREADY(hready_a), .HRESP(hresp_a),
        .HRDATA(hrdata_a), .HSPLIT(hsplit_a), .err_clear(clr_a), .err_valid(ev_a),
        .err_addr(ea_a), .err_master(em_a), .err_write(ew_a), .err_count(ec_a), .state_dbg(st_a)
    );

    ahb_default_slave_ext #(.WAIT_STATES(3), .RESP_MODE(1), .CNT_W(8)) u_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_b), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HMASTER(hmaster),
        .HMASTLOCK(hmastlock), .HREADYIN(hreadyin_b), .HREADY(hready_b), .HRESP(hresp_b),
        .HRDATA(hrdata_b), .HSPLIT(hsplit_b), .err_clear(clr_b), .err_valid(ev_b),
        .err_addr(ea_b), .err_master(em_b), .err_write(ew_b), .err_count(ec_b), .state_dbg(st_b)
    );

    ahb_default_slave_ext #(.WAIT_STATES(1), .RESP_MODE(0), .RDATA_VALUE(32'hDEAD_BEEF), .CNT_W(8)) u_c (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_c), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HMASTER(hmaster),
        .HMASTLOCK(hmastlock), .HREADYIN(hreadyin_c), .HREADY(hready_c), .HRESP(hresp_c),
        .HRDATA(hrdata_c), .HSPLIT(hsplit_c), .err_clear(clr_c), .err_valid(ev_c),
        .err_addr(ea_c), .err_master(em_c), .err_write(ew_c), .err_count(ec_c), .state_dbg(st_c)
    );

    // ---------------- observation mux (selected instance) ----------------
    int cur = 0;
    logic [34:0] obs_resp;   // {HREADY, HRESP, HRDATA}
    logic [3:0]  obs_split;
    logic        obs_valid, obs_write;
    logic [31:0] obs_addr;
    logic [3:0]  obs_master;
    logic [7:0]  obs_count;
    logic [2:0]  obs_state;

    always_comb begin
        obs_resp = '0; obs_split = '0; obs_valid = 1'b0; obs_write = 1'b0;
        obs_addr = '0; obs_master = '0; obs_count = '0; obs_state = '0;
        case (cur)
            0: begin
                obs_resp = {hready_a, hresp_a, hrdata_a}; obs_split = hsplit_a;
                obs_valid = ev_a; obs_addr = ea_a; obs_master = em_a; obs_write = ew_a;
                obs_count = {6'd0, ec_a}; obs_state = st_a;
            end
            1: begin
                obs_resp = {hready_b, hresp_b, hrdata_b}; obs_split = hsplit_b;
                obs_valid = ev_b; obs_addr = ea_b; obs_master = em_b; obs_write = ew_b;
                obs_count = ec_b; obs_state = st_b;
            end
            default: begin
                obs_resp = {hready_c, hresp_c, hrdata_c}; obs_split = hsplit_c;
                obs_valid = ev_c; obs_addr = ea_c; obs_master = em_c; obs_write = ew_c;
                obs_count = ec_c; obs_state = st_c;
            end
        endcase
    end

    // ---------------- scoreboard and reference model ----------------
    logic [34:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Log model per instance
    logic        m_valid[3];
    logic [31:0] m_addr[3];
    logic [3:0]  m_master[3];
    logic        m_write[3];
    int          m_count[3];

    localparam logic [34:0] R_IDLE = {1'b1, 2'b00, 32'h0};
    localparam logic [34:0] R_WAIT = {1'b0, 2'b00, 32'h0};
    localparam logic [34:0] R_ERR1 = {1'b0, 2'b01, 32'h0};
    localparam logic [34:0] R_ERR2 = {1'b1, 2'b01, 32'h0};

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s (inst %0d): observed %0h expected %0h", tag, cur, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0; m_addr[i] = '0; m_master[i] = '0; m_write[i] = 1'b0; m_count[i] = 0;
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, ".err_valid"},  64'(obs_valid),  64'(m_valid[cur]));
        check({tag, ".err_addr"},   64'(obs_addr),   64'(m_addr[cur]));
        check({tag, ".err_master"}, 64'(obs_master), 64'(m_master[cur]));
        check({tag, ".err_write"},  64'(obs_write),  64'(m_write[cur]));
        check({tag, ".err_count"},  64'(obs_count),  64'(m_count[cur]));
    endtask

    // One clock edge; return address-phase inputs to idle and compare the
    // response of the cycle just entered against the scoreboard.
    task automatic tick_and_check(input string tag);
        logic [34:0] e;
        @(posedge HCLK); #1;
        htrans = 2'b00;
        hsel_a = 1'b0; hsel_b = 1'b0; hsel_c = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s: scoreboard empty, observed %0h", tag, obs_resp);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(obs_resp), 64'(e));
        end
    endtask

    // Drive one address phase to the current instance, queue the expected
    // data-phase cycles, update the log model and run until the response is
    // complete (leaving the bench in the last data-phase cycle).
    task automatic send(input string tag, input logic [1:0] trans, input logic [31:0] addr,
                        input logic wr, input logic [3:0] mst, input logic sel, input logic clr);
        logic acc;
        int ws, rm, maxc;
        logic [31:0] rdv;
        case (cur)
            0: begin ws = 0; rm = 1; rdv = 32'h0; maxc = 3; end
            1: begin ws = 3; rm = 1; rdv = 32'h0; maxc = 255; end
            default: begin ws = 1; rm = 0; rdv = 32'hDEAD_BEEF; maxc = 255; end
        endcase
        acc = sel & trans[1] & ~hold;
        htrans = trans; haddr = addr; hwrite = wr; hmaster = mst;
        hwdata = $urandom;
        case (cur)
            0: begin hsel_a = sel; clr_a = clr; end
            1: begin hsel_b = sel; clr_b = clr; end
            default: begin hsel_c = sel; clr_c = clr; end
        endcase
        if (acc) begin
            for (int i = 0; i < ws; i++) exp_q.push_back(R_WAIT);
            if (rm != 0) begin
                exp_q.push_back(R_ERR1);
                exp_q.push_back(R_ERR2);
            end else begin
                exp_q.push_back({1'b1, 2'b00, (wr ? 32'h0 : rdv)});
            end
        end else begin
            exp_q.push_back(R_IDLE);
        end
        if (rm != 0) begin
            if (acc) begin
                if (clr || !m_valid[cur]) begin
                    m_valid[cur] = 1'b1; m_addr[cur] = addr; m_master[cur] = mst; m_write[cur] = wr;
                end
                if (clr) m_count[cur] = 1;
                else if (m_count[cur] < maxc) m_count[cur]++;
            end else if (clr) begin
                m_valid[cur] = 1'b0; m_count[cur] = 0;
            end
        end
        do tick_and_check(tag); while (exp_q.size() != 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            cur = i; #1;
            check("reset.resp", 64'(obs_resp), 64'(R_IDLE));
            check("reset.hsplit", 64'(obs_split), 64'h0);
            check("reset.state", 64'(obs_state), 64'h0);
            check_log("reset");
        end
        HRESETn = 1'b1;

        // Zero-wait ERROR response, log capture
        cur = 0;
        send("a.write_err", 2'b10, 32'h4000_0000, 1'b1, 4'd2, 1'b1, 1'b0);
        send("a.idle", 2'b00, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        check_log("a.first");

        // Three wait states, back-to-back SEQ accepted in ERR2
        cur = 1;
        send("b.read_err", 2'b10, 32'h5000_0010, 1'b0, 4'd1, 1'b1, 1'b0);
        send("b.seq_err", 2'b11, 32'h5000_0014, 1'b1, 4'd3, 1'b1, 1'b0);
        send("b.idle", 2'b00, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        check_log("b.b2b");

        // No accept: IDLE/BUSY selected, HSEL low, HREADYIN low
        send("b.sel_idle", 2'b00, 32'h7000_0000, 1'b0, 4'd1, 1'b1, 1'b0);
        send("b.sel_busy", 2'b01, 32'h7000_0004, 1'b1, 4'd1, 1'b1, 1'b0);
        send("b.unsel", 2'b10, 32'h7000_0008, 1'b1, 4'd1, 1'b0, 1'b0);
        hold = 1'b1;
        send("b.readyin_lo", 2'b10, 32'h7000_000C, 1'b0, 4'd1, 1'b1, 1'b0);
        hold = 1'b0;
        check_log("b.noaccept");

        // OKAY mode: read returns RDATA_VALUE, write returns zero, no logging
        cur = 2;
        send("c.read", 2'b10, 32'h8000_0000, 1'b0, 4'd0, 1'b1, 1'b0);
        send("c.write", 2'b10, 32'h8000_0004, 1'b1, 4'd0, 1'b1, 1'b0);
        send("c.idle", 2'b00, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        check_log("c.raz");

        // Saturation with CNT_W=2 (five errors in total)
        cur = 0;
        for (int i = 0; i < 4; i++) begin
            send("a.sat", 2'b10, 32'h4000_1000 + 32'(i), 1'(i), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
        end
        send("a.idle2", 2'b00, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        check_log("a.saturated");

        // Clear coinciding with a new accept: the new error wins
        send("a.clr_acc", 2'b10, 32'h6000_0000, 1'b0, 4'd3, 1'b1, 1'b1);
        send("a.idle3", 2'b00, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        check_log("a.clear_accept");

        // Clear alone: valid/count drop, captured fields hold
        send("a.clr_only", 2'b00, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        check_log("a.clear_only");

        // Asynchronous reset in the middle of ERR1
        htrans = 2'b10; haddr = 32'h4000_2000; hwrite = 1'b1; hmaster = 4'd5; hsel_a = 1'b1;
        @(posedge HCLK); #1;
        htrans = 2'b00; hsel_a = 1'b0;
        check("a.err1_before_reset", 64'(obs_resp), 64'(R_ERR1));
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check("a.reset_mid_err1.resp", 64'(obs_resp), 64'(R_IDLE));
        check("a.reset_mid_err1.count", 64'(obs_count), 64'h0);
        check("a.reset_mid_err1.state", 64'(obs_state), 64'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        send("a.after_reset", 2'b00, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        check_log("a.after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
